// File: rtl/regfile_pkg.sv
// Shared sizing defaults and clear-sequencer state type for the multi-port register file.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_NUMBER = 32;
  localparam int REG_ADDR_W = $clog2(REG_NUMBER);

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, strobing a zero write per cycle,
// then parks in READY until the next reset.
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = REG_NUMBER,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = RF_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Busy also covers the reset cycle itself so callers never see a stale READY.
  always_comb begin
    busy     = srst || (state_q == RF_CLEAR);
    clr_we   = !srst && (state_q == RF_CLEAR);
    clr_addr = cnt_q;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional hardwired-zero entry, optional write-to-read
// forwarding and a self-clearing storage array (no direct reset on the array).
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int DEPTH    = REG_NUMBER,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                  rf_clk,
  input  logic                  rf_ares,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     rw_dec,
  input  logic [DATA_W-1:0]     w_data_in,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_dec,
  output logic [NRD*DATA_W-1:0] q_out,
  output logic                  rf_busy,
  output logic                  wr_drop
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk     (rf_clk),
    .srst    (rf_ares),
    .busy    (busy),
    .clr_addr(clr_addr),
    .clr_we  (clr_we)
  );

  assign rf_busy = busy;

  // An address is live when it exists and is not the hardwired-zero entry.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_LIM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              wr_drop_q, wr_drop_d;

  always_comb begin
    wr_ok       = wr_en && !busy && addr_live(rw_dec);
    mem_we_d    = clr_we || wr_ok;
    mem_waddr_d = clr_we ? clr_addr : rw_dec;
    mem_wdata_d = clr_we ? '0 : w_data_in;
    wr_drop_d   = wr_en && clr_we;
  end

  always_ff @(posedge rf_clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge rf_clk) begin
    if (rf_ares) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_q, rd_d;

      assign ra = rd_dec[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd_d = rd_q;
        if (rd_en[gi]) begin
          if (busy || !addr_live(ra)) begin
            rd_d = '0;
          end else if ((BYPASS != 0) && wr_ok && (rw_dec == ra)) begin
            rd_d = w_data_in;
          end else begin
            rd_d = mem_q[ra];
          end
        end
      end

      always_ff @(posedge rf_clk) begin
        if (rf_ares) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end

      assign q_out[gi*DATA_W +: DATA_W] = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: two instances (forwarding on / off) share stimulus; expected
// results are queued at drive time and compared one cycle later.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rf_ares = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] rw_dec = '0;
  logic [DW-1:0] w_data_in = '0;
  logic [1:0]    rd_en = '0;
  logic [2*AW-1:0] rd_dec = '0;
  logic [2*DW-1:0] q_a, q_b;
  logic          busy_a, busy_b, drop_a, drop_b;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(DW), .DEPTH(DP), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .rf_clk(clk), .rf_ares(rf_ares), .wr_en(wr_en), .rw_dec(rw_dec), .w_data_in(w_data_in),
    .rd_en(rd_en), .rd_dec(rd_dec), .q_out(q_a), .rf_busy(busy_a), .wr_drop(drop_a)
  );

  register_file_mp #(.DATA_W(DW), .DEPTH(DP), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .rf_clk(clk), .rf_ares(rf_ares), .wr_en(wr_en), .rw_dec(rw_dec), .w_data_in(w_data_in),
    .rd_en(rd_en), .rd_dec(rd_dec), .q_out(q_b), .rf_busy(busy_b), .wr_drop(drop_b)
  );

  typedef struct {
    logic [DW-1:0] q0a, q1a, q0b, q1b;
    logic          drop;
    logic          busy;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    re;
    logic [AW-1:0] r0, r1;
    logic [DW-1:0] e0a, e1a, e0b, e1b;
  } vec_t;

  exp_t  sb[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;
  int    txn = 0;

  logic [DW-1:0] mem_m [DP];
  logic [DW-1:0] qm_a [2];
  logic [DW-1:0] qm_b [2];
  vec_t          tbl [11];

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check_front();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    t = tag_q.pop_front();
    txn++;
    $display("txn %0d %s q_a=%08h/%08h q_b=%08h/%08h busy=%0b drop=%0b",
             txn, t, q_a[DW-1:0], q_a[2*DW-1:DW], q_b[DW-1:0], q_b[2*DW-1:DW], busy_a, drop_a);
    cmp({t, ".q0_byp"},  q_a[DW-1:0],    e.q0a);
    cmp({t, ".q1_byp"},  q_a[2*DW-1:DW], e.q1a);
    cmp({t, ".q0_nob"},  q_b[DW-1:0],    e.q0b);
    cmp({t, ".q1_nob"},  q_b[2*DW-1:DW], e.q1b);
    cmp({t, ".busy"},    {31'd0, busy_a}, {31'd0, e.busy});
    cmp({t, ".drop"},    {31'd0, drop_a}, {31'd0, e.drop});
    cmp({t, ".busy_nob"}, {31'd0, busy_b}, {31'd0, e.busy});
    cmp({t, ".drop_nob"}, {31'd0, drop_b}, {31'd0, e.drop});
  endtask

  // One READY-state transaction; expectations come from the table (use_exp) or the model.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [1:0] re, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input bit use_exp, input logic [DW-1:0] e0a, input logic [DW-1:0] e1a,
                       input logic [DW-1:0] e0b, input logic [DW-1:0] e1b, input string tag);
    exp_t          e;
    logic [AW-1:0] addr;
    logic [DW-1:0] pa [2];
    logic [DW-1:0] pb [2];
    wr_en = we; rw_dec = wa; w_data_in = wd; rd_en = re; rd_dec = {r1, r0};
    for (int p = 0; p < 2; p++) begin
      addr = (p == 0) ? r0 : r1;
      if (!re[p]) begin
        pa[p] = qm_a[p];
        pb[p] = qm_b[p];
      end else if (addr == '0) begin
        pa[p] = '0;
        pb[p] = '0;
      end else if (we && wa == addr) begin
        pa[p] = wd;
        pb[p] = mem_m[addr];
      end else begin
        pa[p] = mem_m[addr];
        pb[p] = mem_m[addr];
      end
    end
    if (use_exp) begin
      pa[0] = e0a; pa[1] = e1a; pb[0] = e0b; pb[1] = e1b;
    end
    qm_a = pa;
    qm_b = pb;
    e.q0a = pa[0]; e.q1a = pa[1]; e.q0b = pb[0]; e.q1b = pb[1];
    e.drop = 1'b0;
    e.busy = 1'b0;
    sb.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    if (we && wa != '0) mem_m[wa] = wd;
    @(negedge clk);
    check_front();
  endtask

  // One reset cycle carrying a write and reads that must be discarded, then the clear
  // sequence is timed; inject>0 issues a write on that CLEAR cycle.
  task automatic reset_clear(input int inject, input string tag);
    exp_t e;
    int   cnt;
    rf_ares = 1'b1; wr_en = 1'b1; rw_dec = 5'd3; w_data_in = 32'hFFFF_FFFF;
    rd_en = 2'b11; rd_dec = {5'd4, 5'd3};
    e.q0a = '0; e.q1a = '0; e.q0b = '0; e.q1b = '0; e.drop = 1'b0; e.busy = 1'b1;
    sb.push_back(e);
    tag_q.push_back({tag, ".reset"});
    @(posedge clk);
    @(negedge clk);
    check_front();
    qm_a[0] = '0; qm_a[1] = '0; qm_b[0] = '0; qm_b[1] = '0;
    rf_ares = 1'b0; wr_en = 1'b0; rd_en = 2'b11; rd_dec = {5'd9, 5'd31};
    cnt = 0;
    while (cnt < 100) begin
      if (!busy_a) break;
      cnt++;
      if (cnt == inject) begin
        wr_en = 1'b1; rw_dec = 5'd9; w_data_in = 32'h0000_1234;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cmp({tag, ".clr_drop"}, {31'd0, drop_a}, {31'd0, (cnt == inject)});
      cmp({tag, ".clr_q0"}, q_a[DW-1:0], '0);
    end
    wr_en = 1'b0; rd_en = 2'b00;
    cmp({tag, ".busy_cycles"}, 32'(cnt), 32'(DP));
    for (int i = 0; i < DP; i++) mem_m[i] = '0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DP; a += 2) begin
      drive(1'b0, '0, '0, 2'b11, AW'(a), AW'(a + 1), 1'b0, '0, '0, '0, '0, tag);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd1,  5'd30, 32'd1,  32'd30, 32'd1,  32'd30};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd5,  5'd26, 32'd5,  32'd26, 32'd5,  32'd26};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd15, 5'd16, 32'd15, 32'd16, 32'd15, 32'd16};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd31, 5'd0,  32'd31, 32'd0,  32'd31, 32'd0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 2'b01, 5'd3,  5'd9,  32'd3,  32'd0,  32'd3,  32'd0};
    tbl[5]  = '{1'b1, 5'd0, 32'hDEADBEEF, 2'b11, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd0,  5'd7,  32'd0,  32'd7,  32'd0,  32'd7};
    tbl[7]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 2'b11, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd7, 32'd7};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd7,  5'd6,  32'hA5A5A5A5, 32'd6, 32'hA5A5A5A5, 32'd6};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 2'b10, 5'd12, 5'd12, 32'hA5A5A5A5, 32'd12, 32'hA5A5A5A5, 32'd12};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd12, 5'd12, 32'd12, 32'd12, 32'd12, 32'd12};

    reset_clear(-1, "por");
    read_all("por_read");

    for (int i = 1; i < DP; i++) begin
      drive(1'b1, AW'(i), DW'(i), 2'b00, '0, '0, 1'b0, '0, '0, '0, '0, "fill");
    end
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].re, tbl[k].r0, tbl[k].r1, 1'b1,
            tbl[k].e0a, tbl[k].e1a, tbl[k].e0b, tbl[k].e1b, $sformatf("vec%0d", k));
    end
    for (int i = 1; i < DP / 2; i++) begin
      drive(1'b0, '0, '0, 2'b11, AW'(i), AW'(DP - 1 - i), 1'b0, '0, '0, '0, '0, "pair");
    end

    reset_clear(-1, "ready_rst");
    read_all("rst_read");

    reset_clear(5, "clr_wr");
    drive(1'b0, '0, '0, 2'b11, 5'd9, 5'd9, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, "clr_target");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers (any value >= 2, not necessarily a power of two).
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write data is forwarded to reads when set.
REQ-006 The block SHALL have localparam ADDR_W, defined as $clog2(DEPTH).
REQ-007 The block SHALL have port rf_clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rf_ares, input, width 1: reset, synchronous and active-high.
REQ-009 The block SHALL have port wr_en, input, width 1: write request.
REQ-010 The block SHALL have port rw_dec, input, width ADDR_W: write address.
REQ-011 The block SHALL have port w_data_in, input, width DATA_W: write data.
REQ-012 The block SHALL have port rd_en, input, width NRD: per-port read request.
REQ-013 The block SHALL have port rd_dec, input, width NRD x ADDR_W: per-port read address.
REQ-014 The block SHALL have port q_out, output, width NRD x DATA_W: per-port registered read data.
REQ-015 The block SHALL have port rf_busy, output, width 1: high while the clear sequence runs.
REQ-016 The block SHALL have port wr_drop, output, width 1: single-cycle pulse, a write was discarded.

Function
REQ-017 The block SHALL implement a two-state FSM: CLEAR and READY; reset forces CLEAR with clear counter = 0.
REQ-018 In CLEAR, each cycle with rf_ares low SHALL write 0 to entry[counter] and increment the counter; at counter == DEPTH-1 the next state SHALL be READY, so CLEAR lasts exactly DEPTH cycles after reset deassertion.
REQ-019 rf_busy SHALL be 1 during reset and in CLEAR, and 0 in READY.
REQ-020 In READY, wr_en=1 SHALL write w_data_in to entry[rw_dec] at the rising edge; the write is visible to non-bypassed reads from the next cycle.
REQ-021 Writes SHALL be ignored without wr_drop when rw_dec >= DEPTH, or when rw_dec == 0 and ZERO_REG=1.
REQ-022 wr_en=1 during CLEAR SHALL be discarded, and wr_drop SHALL pulse high in the following cycle.
REQ-023 For each port i, rd_en[i]=1 SHALL load q_out[i] with entry[rd_dec[i]] at the edge (latency 1 cycle); with rd_en[i]=0, q_out[i] SHALL hold its value.
REQ-024 If BYPASS=1 and, in the same cycle, a valid READY write targets rd_dec[i] with rd_en[i]=1, then q_out[i] SHALL load w_data_in; if BYPASS=0, it SHALL load the pre-write value.
REQ-025 Reads of address 0 with ZERO_REG=1, of addresses >= DEPTH, or any read during CLEAR SHALL return 0.
REQ-026 All NRD ports SHALL operate independently; identical addresses on several ports SHALL return identical data.

Reset
REQ-027 With rf_ares=1 at an edge: all q_out SHALL become 0, wr_drop SHALL become 0, rf_busy SHALL become 1, and the FSM SHALL enter CLEAR with counter 0.
REQ-028 Reset asserted mid-CLEAR or in READY SHALL restart the full DEPTH-cycle clear, and in-flight writes and reads in that cycle SHALL be discarded.
REQ-029 Storage SHALL NOT be reset directly; zeroing SHALL occur only through the CLEAR sequence.

Structure
REQ-030 Package regfile_pkg SHALL hold REG_DATA_W, REG_NUMBER, the derived address width, and the FSM state enum rf_state_t.
REQ-031 The clear FSM and counter SHALL be a sub-module rf_clear_seq, which outputs busy, clear address and clear-write strobe.
REQ-032 The storage array and read/bypass muxing SHALL stay in register_file_mp as a generate loop over NRD.

Verification
REQ-033 Release reset, DEPTH=32 -> rf_busy high for exactly 32 cycles; reading all addresses afterward returns 0.
REQ-034 In READY, write i to address i for 1..31, then read pairs (i, 31-i) on ports 0/1 -> data i and 31-i, each one cycle after rd_en.
REQ-035 Write 0xDEADBEEF to address 0 with ZERO_REG=1 -> subsequent read of address 0 returns 0 and wr_drop stays 0.
REQ-036 Same-cycle write 0xA5A5A5A5 to address 7 and read of address 7 (old value 0x7) -> q_out = 0xA5A5A5A5 with BYPASS=1, and 0x7 with BYPASS=0.
REQ-037 wr_en during cycle 5 of CLEAR -> wr_drop high the next cycle only; the target reads 0 after READY.
REQ-038 Fill registers, assert rf_ares one cycle in READY -> q_out = 0, rf_busy high for 32 cycles, all registers read 0 afterward.
